tff_counter: RTL
================

TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low. Ports SHALL be named clk and reset.
REQ-002 Parameter WIDTH, default 4, SHALL set the counter width in bits, with a legal range of 2..8.
REQ-003 Parameter MODULUS, default 10, SHALL set the count range 0..MODULUS-1, with a legal range of 2..2^WIDTH.
REQ-004 Port clk SHALL be an input, 1 bit wide, and serve as the rising-edge clock.
REQ-005 Port reset SHALL be an input, 1 bit wide, and serve as the asynchronous active-low reset.
REQ-006 Port clr SHALL be an input, 1 bit wide, and serve as the synchronous clear.
REQ-007 Port load SHALL be an input, 1 bit wide, and serve as the synchronous parallel load strobe.
REQ-008 Port load_val SHALL be an input, WIDTH bits wide, and carry the value to load.
REQ-009 Port en SHALL be an input, 1 bit wide, and serve as the count enable.
REQ-010 Port up_dn SHALL be an input, 1 bit wide: 1 counts up, 0 counts down. It exists only under TFF_COUNTER_DOWN_EN.
REQ-011 Port count SHALL be an output, WIDTH bits wide, and carry the registered count value.
REQ-012 Port count_n SHALL be an output, WIDTH bits wide, and equal the bitwise complement of count.
REQ-013 Port tc SHALL be an output, 1 bit wide: the combinational terminal-count flag, high when en=1 and the next step wraps.
REQ-014 Port wrapped SHALL be an output, 1 bit wide: a registered sticky flag that is set on any wrap.
REQ-015 Port load_err SHALL be an output, 1 bit wide: a registered flag that pulses for one cycle after an out-of-range load.

Function
REQ-016 Each count bit SHALL be held in a T flip-flop, with toggle input T[i] = next[i] XOR count[i].
REQ-017 Synchronous control priority per rising edge SHALL be clr > load > en > hold.
REQ-018 On clr=1: count SHALL become 0, wrapped SHALL become 0, and load_err SHALL become 0 on the next edge.
REQ-019 On load=1 with load_val < MODULUS: count SHALL become load_val on the next edge, and load_err SHALL become 0.
REQ-020 On load=1 with load_val >= MODULUS: count SHALL become 0 and load_err SHALL be 1 for exactly one cycle.
REQ-021 On en=1 counting up: count SHALL advance by 1, wrapping from MODULUS-1 to 0.
REQ-022 On en=1 counting down: count SHALL decrement by 1, wrapping from 0 to MODULUS-1.
REQ-023 The latency from any control input to count SHALL be one clock edge; count SHALL never hold a value >= MODULUS.
REQ-024 tc SHALL be 1 exactly when en=1, clr=0, load=0, and count is at the wrap point for the current direction.
REQ-025 wrapped SHALL be set on the edge where a wrap occurs and hold until clr or reset.
REQ-026 When en=0, count SHALL hold its value and tc SHALL be 0.
REQ-027 A change of up_dn SHALL take effect on the same edge it is sampled; there SHALL be no extra state.

Reset
REQ-028 While reset=0, count SHALL be 0, count_n SHALL be all ones, and wrapped, load_err and tc SHALL be 0, regardless of clk.
REQ-029 Reset asserted mid-count SHALL clear the counter immediately; on the first edge after reset deasserts, normal priority SHALL apply.

Configuration
REQ-030 With TFF_COUNTER_DOWN_EN defined, port up_dn SHALL exist and select the count direction.
REQ-031 Without TFF_COUNTER_DOWN_EN, port up_dn SHALL be absent and the block SHALL count up only, with the down-count logic removed.

Structure
REQ-032 Shared package tff_counter_pkg SHALL hold the WIDTH and MODULUS defaults, a direction enum (DIR_UP, DIR_DOWN), and the maximum width constant.
REQ-033 One sub-module, tff_cell, SHALL be instantiated WIDTH times.
REQ-034 tff_cell SHALL have ports clk, T, reset (async active-low), set (sync) and outputs q and qbar.
REQ-035 Next-value, wrap and tc logic SHALL reside in tff_counter, not in tff_cell.

Verification
REQ-036 Reset and hold: with reset=0 and en=1 toggled for 3 cycles, count SHALL be 0, count_n SHALL be 4'hF, and tc SHALL be 0.
REQ-037 Up count and wrap: with MODULUS=10 and en=1 for 12 edges from 0, count SHALL run 1..9, 0, 1, 2; tc SHALL be high while count=9; wrapped SHALL be 1 after the 10th edge.
REQ-038 Load and error: load_val=7 with load=1 SHALL give count=7. load_val=12 SHALL give count=0 and load_err=1 for one cycle. load=1 and clr=1 together SHALL give count=0.
REQ-039 Down wrap (TFF_COUNTER_DOWN_EN defined): with up_dn=0 and en=1 from count=1, count SHALL go 0, then 9; tc SHALL be high at count=0; wrapped SHALL be set.
REQ-040 Mid-count reset: reset pulsed low for 3 ns while count=6, asynchronous to clk, SHALL clear count to 0 immediately; counting SHALL resume 1, 2 after deassertion.
REQ-041 Toggle integrity: for every edge in all of the above scenarios, T[i] into each tff_cell SHALL equal count(t+1)[i] XOR count(t)[i], and count_n SHALL equal ~count.

Source files
------------

// File: rtl/tff_counter_pkg.sv
// Shared defaults, limits and direction encoding for the T-flip-flop modulo counter.
package tff_counter_pkg;

  localparam int TFF_WIDTH_DEF   = 4;
  localparam int TFF_MODULUS_DEF = 10;
  localparam int TFF_MAX_WIDTH   = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low reset and synchronous set.
module tff_cell (
  input  logic clk,
  input  logic T,
  input  logic reset,
  input  logic set,
  output logic q,
  output logic qbar
);

  // q and qbar are both stored so the complement output is registered too
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else if (set) begin
      q    <= 1'b1;
      qbar <= 1'b0;
    end else if (T) begin
      q    <= ~q;
      qbar <= ~qbar;
    end else begin
      q    <= q;
      qbar <= qbar;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// Modulo counter built from T flip-flops with clear, load, enable and flags.
// Define TFF_COUNTER_DOWN_EN to add the up_dn port and down counting.
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH   = TFF_WIDTH_DEF,
  parameter int MODULUS = TFF_MODULUS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
`ifdef TFF_COUNTER_DOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrapped,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] t_s;
  logic             wrap_pt_s;
  logic             load_ok_s;
  logic             tc_s;
  logic             wrapped_r;
  logic             load_err_r;

`ifdef TFF_COUNTER_DOWN_EN
  dir_e dir_s;

  // Direction is taken straight from the pin, no extra state
  always_comb begin
    if (up_dn) begin
      dir_s = DIR_UP;
    end else begin
      dir_s = DIR_DOWN;
    end
  end

  // Wrap point and single step for the selected direction
  always_comb begin
    wrap_pt_s = 1'b0;
    step_s    = count;
    if (dir_s == DIR_UP) begin
      wrap_pt_s = (count == MAX_VAL);
      step_s    = wrap_pt_s ? ZERO_VAL : (count + ONE_VAL);
    end else begin
      wrap_pt_s = (count == ZERO_VAL);
      step_s    = wrap_pt_s ? MAX_VAL : (count - ONE_VAL);
    end
  end
`else
  // Up-only wrap point and single step
  always_comb begin
    wrap_pt_s = (count == MAX_VAL);
    if (wrap_pt_s) begin
      step_s = ZERO_VAL;
    end else begin
      step_s = count + ONE_VAL;
    end
  end
`endif

  assign load_ok_s = ({1'b0, load_val} < MOD_EXT);

  // Next value with clr > load > en > hold; out-of-range loads land on zero
  always_comb begin
    next_s = count;
    if (clr) begin
      next_s = ZERO_VAL;
    end else if (load) begin
      next_s = load_ok_s ? load_val : ZERO_VAL;
    end else if (en) begin
      next_s = step_s;
    end else begin
      next_s = count;
    end
  end

  assign t_s  = next_s ^ count;
  assign tc_s = reset & en & ~clr & ~load & wrap_pt_s;
  assign tc   = tc_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk  (clk),
      .T    (t_s[i]),
      .reset(reset),
      .set  (1'b0),
      .q    (count[i]),
      .qbar (count_n[i])
    );
  end

  // Sticky wrap flag and one-cycle load error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrapped_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else if (clr) begin
      wrapped_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else if (load) begin
      wrapped_r  <= wrapped_r;
      load_err_r <= ~load_ok_s;
    end else begin
      wrapped_r  <= wrapped_r | tc_s;
      load_err_r <= 1'b0;
    end
  end

  assign wrapped  = wrapped_r;
  assign load_err = load_err_r;

endmodule
